// File: rtl/mips_cpu_pkg.sv
// MIPS decode constants and instruction field view shared by the link/RAS stage.
// Pure declarations; no logic, no latency, no flow control.
package mips_cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

endpackage

// File: rtl/mips_cpu_ras.sv
// Circular return-address stack; oldest entry is overwritten when full.
// Latency: push/pop visible on top/valid the cycle after the update.
// Backpressure: none; caller qualifies push/pop with its own accept.
module mips_cpu_ras #(
    parameter int DATA_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_dat,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_inc;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] entries [RAS_DEPTH];
    logic                  full;

    assign ptr_inc = ptr + 1'b1;
    assign full    = (count == CW'(RAS_DEPTH));
    assign valid   = (count != '0);
    assign top     = valid ? entries[ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            // pointer and entries survive; an empty count hides them from top
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push && pop && valid) begin
            entries[ptr] <= push_dat;
        end else if (push) begin
            ptr              <= ptr_inc;
            entries[ptr_inc] <= push_dat;
            if (full) overflow <= 1'b1;
            else      count    <= count + 1'b1;
        end else if (pop) begin
            if (!valid) begin
                underflow <= 1'b1;
            end else begin
                count <= count - 1'b1;
                ptr   <= ptr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_link_ras.sv
// Registered link/writeback stage: redirects link writes and maintains the RAS.
// Latency: 1 cycle from accept to output register.
// Backpressure: in_ready = !out_valid || out_ready; outputs held while stalled.
module mips_cpu_link_ras
    import mips_cpu_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          REG_ADDR_WIDTH = 5,
    parameter int          LINK_REG       = 31,
    parameter int unsigned LINK_OFFSET    = 8,
    parameter int          RAS_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instruction,
    input  logic [DATA_WIDTH-1:0]     pc,
    input  logic                      reg_write_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
    input  logic [DATA_WIDTH-1:0]     reg_write_data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      reg_write_en_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
    output logic [DATA_WIDTH-1:0]     reg_write_data_out,
    output logic [DATA_WIDTH-1:0]     ras_top,
    output logic                      ras_valid,
    output logic                      ras_overflow,
    output logic                      ras_underflow
);

    instr_t                    ins;
    logic                      link_abs, jalr, jr, is_ret, accept;
    logic [DATA_WIDTH-1:0]     link_val;
    logic                      nxt_en;
    logic [REG_ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0]     nxt_dat;
    logic                      unused_fields;

    assign ins           = instruction;
    assign unused_fields = ^{ins.rd, ins.shamt};

    assign link_abs = (ins.op == OP_JAL) ||
                      (ins.op == OP_REGIMM && (ins.rt == RT_BLTZAL || ins.rt == RT_BGEZAL));
    assign jalr     = (ins.op == OP_SPECIAL) && (ins.funct == FN_JALR);
    assign jr       = (ins.op == OP_SPECIAL) && (ins.funct == FN_JR);
    assign is_ret   = (jr || jalr) && (ins.rs == 5'(LINK_REG));
    assign link_val = pc + DATA_WIDTH'(LINK_OFFSET);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        nxt_addr = reg_write_addr_in;
        nxt_dat  = reg_write_data_in;
        nxt_en   = reg_write_en_in && (reg_write_addr_in != '0);
        if (link_abs) begin
            nxt_addr = REG_ADDR_WIDTH'(LINK_REG);
            nxt_dat  = link_val;
            nxt_en   = 1'b1;
        end else if (jalr) begin
            // JALR keeps the upstream rd; writing $0 is suppressed
            nxt_dat  = link_val;
            nxt_en   = (reg_write_addr_in != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid          <= 1'b0;
            reg_write_en_out   <= 1'b0;
            reg_write_addr_out <= '0;
            reg_write_data_out <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid          <= 1'b1;
            reg_write_en_out   <= nxt_en;
            reg_write_addr_out <= nxt_addr;
            reg_write_data_out <= nxt_dat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    mips_cpu_ras #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (accept && !flush && (link_abs || jalr)),
        .pop       (accept && !flush && is_ret),
        .push_dat  (link_val),
        .top       (ras_top),
        .valid     (ras_valid),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_mips_cpu_link_ras.sv
// Scenario bench for mips_cpu_link_ras with an output scoreboard.
module tb_mips_cpu_link_ras;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    localparam logic [31:0] I_JAL    = 32'h0C1F_0400;
    localparam logic [31:0] I_BLTZAL = {6'd1, 5'd3, 5'b10000, 16'h0010};
    localparam logic [31:0] I_JR31   = {6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'b001000};
    localparam logic [31:0] I_JALR0  = {6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'b001001};
    localparam logic [31:0] I_ADDU5  = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100001};
    localparam logic [31:0] I_ADDU6  = {6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'b100001};

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instruction, pc, reg_write_data_in, reg_write_data_out, ras_top;
    logic        reg_write_en_in, reg_write_en_out, ras_valid, ras_overflow, ras_underflow;
    logic [4:0]  reg_write_addr_in, reg_write_addr_out;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mips_cpu_link_ras #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LINK_REG(31), .LINK_OFFSET(8), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .reg_write_data_in(reg_write_data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
        .reg_write_data_out(reg_write_data_out),
        .ras_top(ras_top), .ras_valid(ras_valid),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    // Output monitor: every delivered beat must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && reset_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got en=%0b addr=%0d data=%h, none expected",
                         reg_write_en_out, reg_write_addr_out, reg_write_data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({reg_write_en_out, reg_write_addr_out, reg_write_data_out} !== e) begin
                    errors++;
                    $display("FAIL out_beat: got en=%0b addr=%0d data=%h, want en=%0b addr=%0d data=%h",
                             reg_write_en_out, reg_write_addr_out, reg_write_data_out,
                             e.en, e.addr, e.data);
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] p, input logic wen,
                        input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
        bit done = 0;
        instruction = ins; pc = p; reg_write_en_in = wen;
        reg_write_addr_in = wa; reg_write_data_in = wd; in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed %0b, want 1", in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0; pc = '0; reg_write_en_in = 1'b0;
        reg_write_addr_in = '0; reg_write_data_in = '0;
        #3;
        checks++;
        if ({out_valid, reg_write_en_out, reg_write_addr_out, reg_write_data_out} !== 39'd0) begin
            errors++;
            $display("FAIL reset_out: got v=%0b en=%0b addr=%0d data=%h, want all 0",
                     out_valid, reg_write_en_out, reg_write_addr_out, reg_write_data_out);
        end
        checks++;
        if ({ras_top, ras_valid, ras_overflow, ras_underflow} !== 35'd0) begin
            errors++;
            $display("FAIL reset_ras: got top=%h v=%0b ov=%0b un=%0b, want all 0",
                     ras_top, ras_valid, ras_overflow, ras_underflow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        #9; reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_jal();
        out_ready = 1'b1;
        send(I_JAL, 32'h0000_1000, 1'b0, 5'd7, 32'h55, '{1'b1, 5'd31, 32'h0000_1008});
        in_valid = 1'b0;
        checks++;
        if (ras_top !== 32'h0000_1008 || ras_valid !== 1'b1) begin
            errors++;
            $display("FAIL jal_ras: got top=%h v=%0b, want top=00001008 v=1", ras_top, ras_valid);
        end
        idle();
    endtask

    task automatic test_bltzal_jr();
        do_flush();
        send(I_BLTZAL, 32'h200, 1'b0, 5'd0, 32'h0, '{1'b1, 5'd31, 32'h208});
        send(I_JR31, 32'h300, 1'b0, 5'd0, 32'h0, '{1'b0, 5'd0, 32'h0});
        in_valid = 1'b0;
        checks++;
        if (ras_valid !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL bltzal_jr: got v=%0b un=%0b, want v=0 un=0", ras_valid, ras_underflow);
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [31:0] p;
        logic [31:0] want;
        do_flush();
        for (int i = 1; i <= 5; i++) begin
            p = 32'(i * 16);
            send(I_JAL, p, 1'b0, 5'd0, 32'h0, '{1'b1, 5'd31, p + 32'd8});
        end
        in_valid = 1'b0;
        checks++;
        if (ras_overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_flag: got %0b want 1", ras_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            want = 32'h58 - 32'(i * 16);
            checks++;
            if (ras_top !== want || ras_valid !== 1'b1) begin
                errors++;
                $display("FAIL pop_top_%0d: got top=%h v=%0b, want top=%h v=1", i, ras_top, ras_valid, want);
            end
            send(I_JR31, 32'h600, 1'b0, 5'd0, 32'h0, '{1'b0, 5'd0, 32'h0});
            in_valid = 1'b0;
        end
        checks++;
        if (ras_valid !== 1'b0 || ras_underflow !== 1'b0 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL drained: got v=%0b un=%0b top=%h, want 0 0 0", ras_valid, ras_underflow, ras_top);
        end
        send(I_JR31, 32'h610, 1'b0, 5'd0, 32'h0, '{1'b0, 5'd0, 32'h0});
        in_valid = 1'b0;
        checks++;
        if (ras_valid !== 1'b0 || ras_underflow !== 1'b1 || ras_overflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got v=%0b un=%0b ov=%0b, want 0 1 1", ras_valid, ras_underflow, ras_overflow);
        end
        idle();
    endtask

    task automatic test_jalr();
        do_flush();
        checks++;
        if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_flags: got ov=%0b un=%0b, want 0 0", ras_overflow, ras_underflow);
        end
        send(I_JAL, 32'h100, 1'b0, 5'd0, 32'h0, '{1'b1, 5'd31, 32'h108});
        send(I_JALR0, 32'h400, 1'b1, 5'd0, 32'h0, '{1'b0, 5'd0, 32'h408});
        in_valid = 1'b0;
        checks++;
        if (ras_top !== 32'h408 || ras_valid !== 1'b1) begin
            errors++; $display("FAIL jalr_ras: got top=%h v=%0b, want 408 1", ras_top, ras_valid);
        end
        send(I_JR31, 32'h500, 1'b0, 5'd0, 32'h0, '{1'b0, 5'd0, 32'h0});
        in_valid = 1'b0;
        checks++;
        if (ras_valid !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++;
            $display("FAIL jalr_count: got v=%0b un=%0b, want 0 0", ras_valid, ras_underflow);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_flush();
        out_ready = 1'b0;
        send(I_ADDU5, 32'h700, 1'b1, 5'd5, 32'hDEAD_BEEF, '{1'b1, 5'd5, 32'hDEAD_BEEF});
        instruction = I_ADDU6; pc = 32'h704; reg_write_en_in = 1'b1;
        reg_write_addr_in = 5'd6; reg_write_data_in = 32'h0000_1234; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {reg_write_en_out, reg_write_addr_out, reg_write_data_out} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL stall_%0d: got rdy=%0b v=%0b en=%0b addr=%0d data=%h, want 0 1 1 5 deadbeef",
                         i, in_ready, out_valid, reg_write_en_out, reg_write_addr_out, reg_write_data_out);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(I_ADDU6, 32'h704, 1'b1, 5'd6, 32'h0000_1234, '{1'b1, 5'd6, 32'h0000_1234});
        idle();
    endtask

    task automatic test_reset_mid();
        do_flush();
        send(I_JAL, 32'h10, 1'b0, 5'd0, 32'h0, '{1'b1, 5'd31, 32'h18});
        send(I_JAL, 32'h20, 1'b0, 5'd0, 32'h0, '{1'b1, 5'd31, 32'h28});
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || ras_valid !== 1'b0 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b rv=%0b top=%h, want 0 0 0", out_valid, ras_valid, ras_top);
        end
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_accept();
        out_ready = 1'b1;
        instruction = I_JAL; pc = 32'h800; reg_write_en_in = 1'b0;
        reg_write_addr_in = '0; reg_write_data_in = '0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || ras_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept: got v=%0b rv=%0b, want 0 0", out_valid, ras_valid);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_jal();
        test_bltzal_jr();
        test_overflow();
        test_jalr();
        test_back_to_back();
        test_reset_mid();
        test_flush_accept();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_link_ras.md
Name: mips_cpu_link_ras

Overview:
Registered link/writeback stage with a return-address stack (RAS), replacing the combinational link mux.
- Detects link instructions (JAL, JALR, BGEZAL, BLTZAL) and redirects the write address and data to the link register.
- Pushes the return address onto the RAS; pops it on returns (JR/JALR with rs = LINK_REG).
- Exposes the predicted return target to fetch.
- Sits between execute and register-file write, with a valid/ready handshake on both sides.

Parameters:
DATA_WIDTH, 32, width of PC and data paths
REG_ADDR_WIDTH, 5, register index width
LINK_REG, 31, register written by JAL/BxxAL; return-detection rs value
LINK_OFFSET, 8, added to PC to form link value (delay slot skipped)
RAS_DEPTH, 4, RAS entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills output register and empties RAS
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
instruction  in  32  instruction word
pc  in  DATA_WIDTH  address of instruction
reg_write_en_in  in  1  upstream write enable
reg_write_addr_in  in  REG_ADDR_WIDTH  upstream destination (rd/rt)
reg_write_data_in  in  DATA_WIDTH  upstream result
out_valid  out  1  output register valid
out_ready  in  1  downstream accepts
reg_write_en_out  out  1  registered write enable
reg_write_addr_out  out  REG_ADDR_WIDTH  registered destination
reg_write_data_out  out  DATA_WIDTH  registered write data
ras_top  out  DATA_WIDTH  predicted return address (top entry)
ras_valid  out  1  RAS non-empty
ras_overflow  out  1  sticky: push while full
ras_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (async, reset_n=0): out_valid=0, reg_write_en_out=0, reg_write_addr_out=0, reg_write_data_out=0, RAS count=0, top pointer=0, entries=0, ras_top=0, ras_valid=0, both sticky flags=0.
- Handshake: in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
  - Latency 1: accepted instruction appears on outputs the next cycle.
  - Outputs are held stable while out_valid && !out_ready.
  - When out_ready && !accept, out_valid clears next cycle.
- Decode (combinational on instruction):
  - link_abs = JAL (op 000011) or REGIMM (op 000001) with rt 10000/10001.
  - jalr = op 0, funct 001001.
  - jr = op 0, funct 001000.
  - is_ret = (jr || jalr) && rs == LINK_REG.
- Output data on accept:
  - link_abs: addr = LINK_REG, data = pc + LINK_OFFSET (modulo 2^DATA_WIDTH), en = 1.
  - jalr: addr = reg_write_addr_in, data = pc + LINK_OFFSET, en = (reg_write_addr_in != 0).
  - Otherwise: pass addr, data and en through; en is forced 0 when addr == 0.
- BxxAL links and pushes whether or not the branch is taken.
- RAS, updated only on accept:
  - push when link_abs || jalr; pop when is_ret.
  - pop only: count -= 1, pointer -= 1.
  - push only: pointer += 1 (mod depth), entry = pc + LINK_OFFSET, count saturates at RAS_DEPTH.
  - Push while full overwrites the oldest entry (circular) and sets ras_overflow.
  - Pop while empty: no change; sets ras_underflow.
  - Push + pop together (JALR rs=31): top entry replaced, pointer and count unchanged.
  - Empty + push + pop: behaves as a push; no underflow.
- ras_top = entry at pointer when count > 0, else 0. ras_valid = (count != 0). Both are combinational from state.
- flush:
  - Next cycle: out_valid=0, count=0, sticky flags cleared.
  - Pointer and entries are kept, so no data reaches the outputs.
  - flush with a simultaneous accept: flush wins; nothing registered, no RAS update.
- Parameter width rules: LINK_OFFSET is zero-extended to DATA_WIDTH. The count register is clog2(RAS_DEPTH)+1 bits.

Decomposition:
- Package mips_cpu_pkg holds:
  - opcode/funct/rt constants: OP_SPECIAL, OP_REGIMM, OP_JAL, FN_JR, FN_JALR, RT_BLTZAL, RT_BGEZAL;
  - an instr_t struct with op, rs, rt, rd, funct field views.
- Sub-module mips_cpu_ras: circular stack with push, pop, flush, top, valid, overflow, underflow; parameters DATA_WIDTH and RAS_DEPTH.
- The top level holds decode, link mux and the output register.

Test Plan:
- JAL at pc=0x0000_1000, rt field arbitrary, out_ready=1 → next cycle: addr=31, data=0x0000_1008, en=1, ras_top=0x0000_1008, ras_valid=1.
- BLTZAL pc=0x200 (not taken), then JR $31 pc=0x300 → first output: addr=31, data=0x208; after JR: ras_valid=0, ras_underflow=0.
- Five JALs at pc=0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4 → ras_overflow=1. Then four JR $31 give ras_top 0x58, 0x48, 0x38, 0x28 in turn. A fifth JR leaves ras_valid=0 and sets ras_underflow=1.
- JALR rd=0, rs=31 at pc=0x400 after JAL at pc=0x100 → output en=0. ras_top becomes 0x408; count stays 1.
- Backpressure: out_ready=0 for 3 cycles with ADDU result 0xDEAD_BEEF to rd=5, while a second instruction is held valid → in_ready=0 and outputs stable. Release gives ordered delivery.
- reset_n pulsed low mid-stream after two JALs (async, between edges) → out_valid and ras_valid drop immediately. flush concurrent with accept of JAL → no output, ras_valid=0.
